// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and default widths/vectors
// used by the fetch stage and its neighbours.
package cpu_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: sequences the PC, fetches one word at a time over req/ack and
// hands it to decode over valid/ready. Optional PC cross-check: FETCH_PC_CHECK_EN.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic               pc_ce,
    output logic               pc_load,
    output logic [ADDR_W-1:0]  pc_target,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] ir,
    output logic [ADDR_W-1:0]  ir_addr,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               pc_mismatch
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] fetch_addr, fetch_addr_next;
    logic [ADDR_W-1:0] drain_addr, drain_addr_next;
    logic              capture;

    always_comb begin
        state_next      = state;
        fetch_addr_next = fetch_addr;
        drain_addr_next = drain_addr;
        capture         = 1'b0;
        pc_ce           = 1'b0;
        pc_load         = 1'b0;
        pc_target       = RESET_VECTOR;

        if (redirect) begin
            pc_load         = 1'b1;
            pc_target       = redirect_addr;
            fetch_addr_next = redirect_addr;
            // An unacked request stays outstanding at its original address.
            if ((state == ST_REQ || state == ST_DRAIN) && !mem_ack) begin
                state_next = ST_DRAIN;
                if (state == ST_REQ) drain_addr_next = fetch_addr;
            end else begin
                state_next = ST_REQ;
            end
        end else begin
            unique case (state)
                ST_BOOT: begin
                    pc_load    = 1'b1;
                    state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        capture         = 1'b1;
                        fetch_addr_next = fetch_addr + 1'b1;
                        pc_ce           = 1'b1;
                        state_next      = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ir_ready) state_next = ST_REQ;
                end
                ST_DRAIN: begin
                    if (mem_ack) state_next = ST_REQ;
                end
                default: state_next = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            fetch_addr <= RESET_VECTOR;
            ir         <= '0;
            ir_addr    <= '0;
        end else begin
            state      <= state_next;
            fetch_addr <= fetch_addr_next;
            if (capture) begin
                ir      <= mem_data;
                ir_addr <= fetch_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        drain_addr <= drain_addr_next;
    end

    assign mem_req  = (state == ST_REQ) || (state == ST_DRAIN);
    assign mem_addr = (state == ST_DRAIN) ? drain_addr : fetch_addr;
    assign ir_valid = (state == ST_HOLD);

`ifdef FETCH_PC_CHECK_EN
    // The PC only reflects a load one edge later, so skip that cycle.
    logic load_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_d      <= 1'b0;
            pc_mismatch <= 1'b0;
        end else begin
            load_d <= pc_load;
            if (state == ST_REQ && !load_d && pc_in != fetch_addr)
                pc_mismatch <= 1'b1;
        end
    end
`else
    logic unused_pc_in;
    assign unused_pc_in = ^pc_in;
    assign pc_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and a
// variable-latency instruction memory.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        pc_ce, pc_load;
    logic [15:0] pc_target;
    logic        mem_req, mem_ack;
    logic [15:0] mem_addr, mem_data;
    logic [15:0] ir, ir_addr;
    logic        ir_valid, ir_ready;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        pc_mismatch;

    int tests = 0;
    int fails = 0;

    logic [15:0] pc = 16'h0000;
    logic [15:0] pc_off = 16'h0000;
    int          lat = 0;
    int          cnt;
    logic        exp_mm;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_ce(pc_ce), .pc_load(pc_load),
        .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .ir(ir), .ir_addr(ir_addr),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect),
        .redirect_addr(redirect_addr), .pc_mismatch(pc_mismatch)
    );

    function automatic logic [15:0] word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    always_ff @(posedge clk) begin
        if (pc_load) pc <= pc_target;
        else if (pc_ce) pc <= pc + 16'd1;
    end
    assign pc_in = pc + pc_off;

    always_ff @(posedge clk) begin
        if (!rst_n || !mem_req || mem_ack) cnt <= 0;
        else cnt <= cnt + 1;
    end
    assign mem_ack  = mem_req && (cnt >= lat);
    assign mem_data = word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
`ifdef FETCH_PC_CHECK_EN
        exp_mm = 1'b1;
`else
        exp_mm = 1'b0;
`endif
        rst_n = 1'b0; ir_ready = 1'b1; redirect = 1'b0; redirect_addr = 16'h0;
        repeat (3) cyc();
        chk("rst_ir_valid", ir_valid, 0);
        chk("rst_ir", ir, 0);
        chk("rst_ir_addr", ir_addr, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mismatch", pc_mismatch, 0);
        rst_n = 1'b1;
        #1;
        chk("boot_pc_load", pc_load, 1);
        chk("boot_pc_target", pc_target, 16'h0000);
        chk("boot_pc_ce", pc_ce, 0);

        // zero-wait streaming, one instruction per two cycles
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("zw_mem_req", mem_req, 1);
            chk("zw_mem_addr", mem_addr, i);
            chk("zw_pc_ce", pc_ce, 1);
            chk("zw_pc_load", pc_load, 0);
            chk("zw_valid_low", ir_valid, 0);
            cyc();
            chk("zw_valid", ir_valid, 1);
            chk("zw_ir_addr", ir_addr, i);
            chk("zw_ir", ir, word(16'(i)));
            chk("zw_pc_ce_hold", pc_ce, 0);
        end

        // decoder stalls for 5 cycles
        ir_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", ir_valid, 1);
            chk("stall_ir_addr", ir_addr, 16'd2);
            chk("stall_ir", ir, word(16'd2));
            chk("stall_mem_req", mem_req, 0);
            chk("stall_pc_ce", pc_ce, 0);
        end
        ir_ready = 1'b1;
        lat = 2;

        // memory acks in the third request cycle
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("wait_mem_req", mem_req, 1);
            chk("wait_mem_addr", mem_addr, 16'd3);
            chk("wait_pc_ce", pc_ce, 0);
            chk("wait_valid", ir_valid, 0);
        end
        cyc();
        chk("wait_ack", mem_ack, 1);
        chk("wait_mem_addr3", mem_addr, 16'd3);
        chk("wait_pc_ce_ack", pc_ce, 1);
        cyc();
        chk("wait_valid_after", ir_valid, 1);
        chk("wait_ir", ir, word(16'd3));
        chk("wait_ir_addr", ir_addr, 16'd3);
        chk("wait_pc", pc_in, 16'd4);

        // redirect while a request is waiting
        cyc();
        chk("rd_mem_addr", mem_addr, 16'd4);
        redirect = 1'b1; redirect_addr = 16'h0040;
        #1;
        chk("rd_pc_load", pc_load, 1);
        chk("rd_pc_target", pc_target, 16'h0040);
        chk("rd_pc_ce", pc_ce, 0);
        cyc();
        redirect = 1'b0;
        #1;
        chk("drain_mem_req", mem_req, 1);
        chk("drain_mem_addr", mem_addr, 16'd4);
        chk("drain_valid", ir_valid, 0);
        chk("drain_pc_load", pc_load, 0);
        cyc();
        chk("drain_ack", mem_ack, 1);
        chk("drain_pc_ce", pc_ce, 0);
        chk("drain_mem_addr2", mem_addr, 16'd4);
        cyc();
        lat = 0;
        #1;
        chk("rd_next_addr", mem_addr, 16'h0040);
        chk("rd_ir_kept", ir, word(16'd3));
        chk("rd_pc", pc_in, 16'h0040);
        chk("rd_req_pc_ce", pc_ce, 1);
        cyc();
        chk("rd_ir_addr", ir_addr, 16'h0040);
        chk("rd_ir", ir, word(16'h0040));

        // redirect to the top of memory, check wrap
        redirect = 1'b1; redirect_addr = 16'hFFFF;
        #1;
        chk("wrap_pc_load", pc_load, 1);
        chk("wrap_pc_target", pc_target, 16'hFFFF);
        cyc();
        redirect = 1'b0;
        #1;
        chk("wrap_valid_drop", ir_valid, 0);
        chk("wrap_mem_addr", mem_addr, 16'hFFFF);
        chk("wrap_pc_ce", pc_ce, 1);
        cyc();
        chk("wrap_ir_addr", ir_addr, 16'hFFFF);
        chk("wrap_ir", ir, word(16'hFFFF));
        lat = 3;
        cyc();
        chk("wrap_next_addr", mem_addr, 16'h0000);
        chk("wrap_pc", pc_in, 16'h0000);

        // PC consistency check
        pc_off = 16'd1;
        cyc();
        pc_off = 16'd0;
        chk("mm_set", pc_mismatch, exp_mm);
        cyc();
        chk("mm_sticky", pc_mismatch, exp_mm);
        chk("mm_still_req", mem_req, 1);

        // reset in the middle of a waiting request
        rst_n = 1'b0;
        cyc();
        chk("mrst_valid", ir_valid, 0);
        chk("mrst_ir", ir, 0);
        chk("mrst_ir_addr", ir_addr, 0);
        chk("mrst_mem_req", mem_req, 0);
        chk("mrst_mismatch", pc_mismatch, 0);
        chk("mrst_pc_load", pc_load, 1);
        chk("mrst_pc_target", pc_target, 16'h0000);
        rst_n = 1'b1;
        lat = 0;
        cyc();
        chk("mrst_req", mem_req, 1);
        chk("mrst_mem_addr", mem_addr, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
